pipe_hazard_ctrl: RTL and testbench

Parametrised hazard, forwarding and flush controller for the 5-stage MIPS pipeline. It replaces the ad-hoc compare logic in the top level with a registered scoreboard. The scoreboard tracks in-flight destination registers across PIPE_DEPTH post-decode stages. Per cycle, the block produces stall, flush and per-operand forwarding selects in either forwarding or stall-only mode, and keeps saturating event counters.

---
 rtl/pipe_hazard_ctrl.sv | 84 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for the 5-stage pipeline.
// A shift-register scoreboard tracks in-flight destinations; stall/flush/fwd_sel are combinational.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int SEL_W      = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fwd_en,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_use_src2,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic [SEL_W-1:0]      fwd_sel1,
  output logic [SEL_W-1:0]      fwd_sel2,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int CMP = PIPE_DEPTH - 1;

  // The WB slot is resolved by the register file and never compared, so only
  // the compared slots are stored; the load flag only matters in the EXE slot.
  logic [CMP-1:0]                 vld_pipe;
  logic [CMP-1:0][REG_ADDR_W-1:0] dest_pipe;
  logic                           ld0;

  logic [SEL_W-1:0] young1, young2;
  logic             load_use, hazard_any, issue;

  function automatic logic src_hit(input logic v, input logic [REG_ADDR_W-1:0] dest,
                                   input logic [REG_ADDR_W-1:0] src, input logic use_src);
    return use_src & id_valid & v & (dest == src) & (src != '0);
  endfunction

  // Scan oldest to youngest so the lowest matching slot wins.
  always_comb begin
    young1 = '0;
    young2 = '0;
    for (int k = CMP - 1; k >= 0; k--) begin
      if (src_hit(vld_pipe[k], dest_pipe[k], id_src1, id_use_src1)) young1 = SEL_W'(k + 1);
      if (src_hit(vld_pipe[k], dest_pipe[k], id_src2, id_use_src2)) young2 = SEL_W'(k + 1);
    end
  end

  assign load_use   = ld0 & ((young1 == SEL_W'(1)) | (young2 == SEL_W'(1)));
  assign hazard_any = (young1 != '0) | (young2 != '0);

  assign flush    = branch_taken;
  assign stall    = ~rst & ~branch_taken & (fwd_en ? load_use : hazard_any);
  assign fwd_sel1 = (fwd_en & ~rst) ? young1 : '0;
  assign fwd_sel2 = (fwd_en & ~rst) ? young2 : '0;
  assign issue    = id_valid & id_wb_en & (id_dest != '0) & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      dest_pipe <= '0;
      ld0       <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      for (int k = 1; k < CMP; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        dest_pipe[k] <= dest_pipe[k-1];
      end
      vld_pipe[0]  <= issue;
      dest_pipe[0] <= issue ? id_dest : '0;
      ld0          <= issue & id_mem_r_en;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (depth 3 / 16-bit counters and
// depth 5 / 2-bit counters) share stimulus and are checked against an age-list model.
module tb_pipe_hazard_ctrl;
  logic clk = 0;
  logic rst = 1, fwd_en = 1, id_valid = 0, id_use_src1 = 0, id_use_src2 = 0;
  logic id_wb_en = 0, id_mem_r_en = 0, branch_taken = 0;
  logic [4:0] id_src1 = 0, id_src2 = 0, id_dest = 0;

  logic stall_a, flush_a, stall_b, flush_b;
  logic [2:0] sel1_a, sel2_a, sel1_b, sel2_b;
  logic [15:0] scnt_a, fcnt_a;
  logic [1:0] scnt_b, fcnt_b;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .PIPE_DEPTH(3), .SEL_W(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .branch_taken(branch_taken), .stall(stall_a), .flush(flush_a), .fwd_sel1(sel1_a),
    .fwd_sel2(sel2_a), .stall_cnt(scnt_a), .flush_cnt(fcnt_a));

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .PIPE_DEPTH(5), .SEL_W(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .branch_taken(branch_taken), .stall(stall_b), .flush(flush_b), .fwd_sel1(sel1_b),
    .fwd_sel2(sel2_b), .stall_cnt(scnt_b), .flush_cnt(fcnt_b));

  typedef struct {int stall; int flush; int sel1; int sel2; int scnt; int fcnt;} exp_t;
  typedef struct {bit v; int dest; bit ld;} rec_t;

  exp_t qa[$], qb[$];
  exp_t ma, mb;
  // hist[m][age]: what was issued 'age' cycles before the instruction now in ID
  rec_t hist[2][8];
  int cs[2], cf[2];
  int dep[2]  = '{3, 5};
  int cmax[2] = '{65535, 3};
  bit r_cur = 1, f_cur = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int youngest(input int m, input bit use_src, input int src);
    if (!id_valid || !use_src || src == 0) return -1;
    for (int a = 0; a < dep[m] - 1; a++)
      if (hist[m][a].v && hist[m][a].dest == src) return a;
    return -1;
  endfunction

  function automatic exp_t predict(input int m);
    exp_t e;
    int y1, y2;
    y1 = youngest(m, id_use_src1, int'(id_src1));
    y2 = youngest(m, id_use_src2, int'(id_src2));
    e = '{0, 0, 0, 0, cs[m], cf[m]};
    e.flush = branch_taken ? 1 : 0;
    if (!rst) begin
      if (fwd_en) begin
        e.sel1 = y1 + 1;
        e.sel2 = y2 + 1;
        e.stall = ((y1 == 0 || y2 == 0) && hist[m][0].ld && !branch_taken) ? 1 : 0;
      end else begin
        e.stall = ((y1 >= 0 || y2 >= 0) && !branch_taken) ? 1 : 0;
      end
    end
    return e;
  endfunction

  task automatic advance(input int m, input exp_t e);
    if (rst) begin
      for (int a = 0; a < 8; a++) hist[m][a] = '{0, 0, 0};
      cs[m] = 0;
      cf[m] = 0;
    end else begin
      if (e.stall == 1 && cs[m] < cmax[m]) cs[m]++;
      if (e.flush == 1 && cf[m] < cmax[m]) cf[m]++;
      for (int a = 7; a > 0; a--) hist[m][a] = hist[m][a-1];
      hist[m][0].v    = id_valid && id_wb_en && id_dest != 0 && e.stall == 0 && !branch_taken;
      hist[m][0].dest = int'(id_dest);
      hist[m][0].ld   = id_mem_r_en;
    end
  endtask

  task automatic drive(input bit v, input int d, input int s1, input int s2, input bit u1,
                       input bit u2, input bit wb, input bit ld, input bit br);
    exp_t ea, eb;
    @(posedge clk);
    #1;
    rst = r_cur; fwd_en = f_cur; id_valid = v;
    id_dest = 5'(d); id_src1 = 5'(s1); id_src2 = 5'(s2);
    id_use_src1 = u1; id_use_src2 = u2; id_wb_en = wb; id_mem_r_en = ld; branch_taken = br;
    ea = predict(0);
    eb = predict(1);
    qa.push_back(ea);
    qb.push_back(eb);
    advance(0, ea);
    advance(1, eb);
    #1;
  endtask

  task automatic ins(input int d, input int s1, input int s2, input bit u1, input bit u2, input bit ld);
    drive(1, d, s1, s2, u1, u2, 1, ld, 0);
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic drain();
    repeat (6) idle();
  endtask

  // Monitor: outputs are combinational, so every cycle presents one response per instance.
  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ma = qa.pop_front();
      chk("a_stall", 32'(stall_a), ma.stall); chk("a_flush", 32'(flush_a), ma.flush);
      chk("a_sel1", 32'(sel1_a), ma.sel1);    chk("a_sel2", 32'(sel2_a), ma.sel2);
      chk("a_scnt", 32'(scnt_a), ma.scnt);    chk("a_fcnt", 32'(fcnt_a), ma.fcnt);
    end
    if (qb.size() > 0) begin
      mb = qb.pop_front();
      chk("b_stall", 32'(stall_b), mb.stall); chk("b_flush", 32'(flush_b), mb.flush);
      chk("b_sel1", 32'(sel1_b), mb.sel1);    chk("b_sel2", 32'(sel2_b), mb.sel2);
      chk("b_scnt", 32'(scnt_b), mb.scnt);    chk("b_fcnt", 32'(fcnt_b), mb.fcnt);
    end
  end

  initial begin
    int n;
    for (int m = 0; m < 2; m++) begin
      cs[m] = 0; cf[m] = 0;
      for (int a = 0; a < 8; a++) hist[m][a] = '{0, 0, 0};
    end
    r_cur = 1; f_cur = 1;
    repeat (2) idle();
    r_cur = 0;
    repeat (10) idle();
    chk("idle_stall", 32'(stall_a), 0); chk("idle_sel1", 32'(sel1_a), 0);
    chk("idle_scnt", 32'(scnt_a), 0);   chk("idle_fcnt", 32'(fcnt_a), 0);

    // forward from EXE, MEM, and youngest of two writers
    ins(3, 1, 2, 1, 1, 0); ins(4, 3, 3, 1, 1, 0);
    chk("fwd_exe_sel1", 32'(sel1_a), 1); chk("fwd_exe_sel2", 32'(sel2_a), 1);
    chk("fwd_exe_stall", 32'(stall_a), 0);
    drain();
    ins(3, 1, 2, 1, 1, 0); ins(6, 1, 2, 1, 1, 0); ins(4, 3, 0, 1, 0, 0);
    chk("fwd_mem_sel1", 32'(sel1_a), 2);
    drain();
    ins(3, 1, 2, 1, 1, 0); ins(3, 2, 1, 1, 1, 0); ins(4, 3, 3, 1, 1, 0);
    chk("fwd_young_sel1", 32'(sel1_a), 1); chk("fwd_young_sel2", 32'(sel2_a), 1);
    drain();

    // load-use: one stall, then forward from MEM
    ins(5, 1, 0, 1, 0, 1); ins(8, 5, 0, 1, 0, 0);
    chk("lu_stall", 32'(stall_a), 1);
    ins(8, 5, 0, 1, 0, 0);
    chk("lu_release", 32'(stall_a), 0); chk("lu_sel1", 32'(sel1_a), 2);
    chk("lu_scnt", 32'(scnt_a), 1);
    drain();

    // stall-only mode: reader held in ID while stalled
    f_cur = 0;
    ins(7, 1, 2, 1, 1, 0);
    n = 0;
    do begin
      ins(9, 7, 0, 1, 0, 0);
      if (stall_a) n++;
    end while (stall_a && n < 8);
    chk("so_len_a", n, 2); chk("so_sel", 32'(sel1_a), 0);
    chk("so_scnt", 32'(scnt_a), 3); chk("sat_b", 32'(scnt_b), 3);
    drain();
    ins(7, 1, 2, 1, 1, 0); ins(9, 7, 0, 0, 1, 0);
    chk("so_nouse", 32'(stall_a), 0);
    ins(10, 0, 0, 1, 1, 0);
    chk("so_r0", 32'(stall_a), 0);
    drain();
    ins(7, 1, 2, 1, 1, 0);
    n = 0;
    do begin
      ins(11, 7, 0, 1, 0, 0);
      if (stall_b) n++;
    end while (stall_b && n < 8);
    chk("so_len_b", n, 4);
    drain();

    // flush beats a load-use stall and squashes the ID instruction
    f_cur = 1;
    ins(5, 1, 0, 1, 0, 1);
    drive(1, 10, 5, 0, 1, 0, 1, 0, 1);
    chk("fp_stall", 32'(stall_a), 0); chk("fp_flush", 32'(flush_a), 1);
    ins(12, 10, 0, 1, 0, 0);
    chk("fp_bubble", 32'(sel1_a), 0); chk("fp_next_stall", 32'(stall_a), 0);
    chk("fp_fcnt", 32'(fcnt_a), 1);
    drain();

    // reset in the middle of a stall drops the hazard
    f_cur = 0;
    ins(7, 1, 2, 1, 1, 0); ins(9, 7, 0, 1, 0, 0);
    chk("mr_pre_stall", 32'(stall_a), 1);
    r_cur = 1;
    ins(9, 7, 0, 1, 0, 0);
    chk("mr_rst_stall", 32'(stall_a), 0);
    r_cur = 0;
    ins(9, 7, 0, 1, 0, 0);
    chk("mr_post_stall", 32'(stall_a), 0); chk("mr_scnt", 32'(scnt_a), 0);
    drain();

    // deep pipe: forward from the fourth compared slot
    f_cur = 1;
    ins(3, 1, 2, 1, 1, 0); ins(6, 1, 2, 1, 1, 0); ins(13, 1, 2, 1, 1, 0);
    ins(14, 1, 2, 1, 1, 0); ins(4, 3, 0, 1, 0, 0);
    chk("b_sel4", 32'(sel1_b), 4); chk("a_sel_gone", 32'(sel1_a), 0);
    drain();

    // random traffic with mode flips, branches and occasional reset
    repeat (3000) begin
      r_cur = ($urandom_range(99) == 0);
      if ($urandom_range(15) == 0) f_cur = ~f_cur;
      drive($urandom_range(3) != 0, $urandom_range(7), $urandom_range(7), $urandom_range(7),
            1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(3) != 0,
            $urandom_range(2) == 0, $urandom_range(9) == 0);
    end
    r_cur = 0;
    drain();

    repeat (2) @(posedge clk);
    chk("queue_drained", qa.size() + qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
